// File: rtl/lane_ser_pkg.sv
// lane_ser_pkg: shared types and helpers for the lane serializer.
//   ser_state_e : serializer FSM states
//   beats_f     : number of beats per word (DATA_WIDTH / LANES)
//   slice_f     : extracts beat k of a word, MSB-first or LSB-first
package lane_ser_pkg;

  // Widest word the slice helper handles.
  localparam int unsigned SER_MAX_W = 256;

  typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_PARITY} ser_state_e;

  function automatic int unsigned beats_f(input int unsigned data_width,
                                          input int unsigned lanes);
    return data_width / lanes;
  endfunction

  // Beat k of a zero-extended word; the result is right-aligned in the low `lanes` bits.
  function automatic logic [SER_MAX_W-1:0] slice_f(input logic [SER_MAX_W-1:0] data,
                                                   input int unsigned data_width,
                                                   input int unsigned lanes,
                                                   input int unsigned k,
                                                   input bit msb_first);
    logic [SER_MAX_W-1:0] mask;
    int unsigned          lsb;
    mask = '1;
    mask = mask >> (SER_MAX_W - lanes);
    lsb  = msb_first ? (data_width - (k + 1) * lanes) : (k * lanes);
    return (data >> lsb) & mask;
  endfunction

endpackage

// File: rtl/lane_ser_hold_buf.sv
// lane_ser_hold_buf: one-entry hold register for the lane serializer.
// Ports:
//   clk, rst, enable : clock, sync active-high reset, enable (low clears)
//   in_data/in_valid : word offered for holding
//   in_ready         : buffer empty, block enabled and out of reset
//   pop              : consumer takes the held word this edge
//   out_data/out_valid : held word and its valid flag
module lane_ser_hold_buf
  import lane_ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  assign in_ready  = enable && !rst && !r_valid;
  assign out_data  = r_data;
  assign out_valid = r_valid;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (pop) begin
      r_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// lane_serializer: multi-lane parallel-to-serial converter with a one-word
// hold buffer so back-to-back words stream without gaps.
// Optional feature: define LANE_SERIALIZER_PARITY_EN to append one even
// parity beat per lane after each word.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enable      : low flushes the block on the next edge
//   in_data/in_valid/in_ready : word input handshake
//   serial_out  : current beat, bit i drives lane i
//   out_valid/out_first/out_last : beat qualifiers
module lane_serializer
  import lane_ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANES-1:0]      serial_out,
  output logic                  out_valid,
  output logic                  out_first,
  output logic                  out_last
);

  localparam int unsigned BEATS    = beats_f(DATA_WIDTH, LANES);
  localparam int unsigned CW       = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  function automatic logic [LANES-1:0] beat_f(input logic [DATA_WIDTH-1:0] w,
                                              input int unsigned k);
    return LANES'(slice_f(SER_MAX_W'(w), DATA_WIDTH, LANES, k, MSB_FIRST != 0));
  endfunction

  ser_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_word;
  logic [CW-1:0]         r_cnt;
  logic [LANES-1:0]      r_serial;
  logic                  r_valid;
  logic                  r_first;
  logic                  r_last;

  logic                  w_in_ready;
  logic                  w_hold_valid;
  logic [DATA_WIDTH-1:0] w_hold_data;
  logic                  w_free;
  logic                  w_accept;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_data;

`ifdef LANE_SERIALIZER_PARITY_EN
  logic [LANES-1:0]      w_parity;

  // Order-independent: per-lane XOR over every beat of the word.
  always_comb begin
    w_parity = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      w_parity = w_parity ^ beat_f(r_word, k);
    end
  end

  assign w_free = (r_state == SER_IDLE) || (r_state == SER_PARITY);
`else
  assign w_free = (r_state == SER_IDLE) ||
                  ((r_state == SER_SHIFT) && (r_cnt == LAST_CNT));
`endif

  assign w_accept    = in_valid && w_in_ready;
  // in_ready is low whenever the hold buffer is full, so a pop and a new
  // acceptance never coincide.
  assign w_load      = w_free && (w_hold_valid || w_accept);
  assign w_load_data = w_hold_valid ? w_hold_data : in_data;

  lane_ser_hold_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid && !w_free),
    .in_ready  (w_in_ready),
    .pop       (w_free && w_hold_valid),
    .out_data  (w_hold_data),
    .out_valid (w_hold_valid)
  );

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state  <= SER_IDLE;
      r_word   <= '0;
      r_cnt    <= '0;
      r_serial <= '0;
      r_valid  <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_load) begin
      r_state  <= SER_SHIFT;
      r_word   <= w_load_data;
      r_cnt    <= '0;
      r_serial <= beat_f(w_load_data, 0);
      r_valid  <= 1'b1;
      r_first  <= 1'b1;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        SER_SHIFT: begin
          if (r_cnt != LAST_CNT) begin
            r_cnt    <= r_cnt + CW'(1);
            r_serial <= beat_f(r_word, 32'(r_cnt) + 32'd1);
            r_first  <= 1'b0;
`ifdef LANE_SERIALIZER_PARITY_EN
            r_last   <= 1'b0;
`else
            r_last   <= ((r_cnt + CW'(1)) == LAST_CNT);
`endif
          end else begin
`ifdef LANE_SERIALIZER_PARITY_EN
            r_state  <= SER_PARITY;
            r_serial <= w_parity;
            r_first  <= 1'b0;
            r_last   <= 1'b1;
`else
            r_state  <= SER_IDLE;
            r_serial <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state  <= SER_IDLE;
          r_serial <= '0;
          r_valid  <= 1'b0;
          r_first  <= 1'b0;
          r_last   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign serial_out = r_serial;
  assign out_valid  = r_valid;
  assign out_first  = r_first;
  assign out_last   = r_last;

endmodule
